// File: rtl/data_bus_responder_pkg.sv
// Shared types for the data bus responder.
//   width_e      : access width/sign encoding carried on f3
//   resp_state_e : responder FSM states
//   load_extend  : selects a byte/half lane from a RAM word and extends it
//   store_be     : byte-enable mask for a store of the given width and lane
//   store_data   : replicates store data so every enabled lane sees it
package data_bus_responder_pkg;

    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HALF   = 3'd1,
        WORD   = 3'd2,
        BYTE_U = 3'd4,
        HALF_U = 3'd5
    } width_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resp_state_e;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {lane, 3'b000};
        res = 32'd0;
        case (f3)
            BYTE:    res = {{24{sh[7]}}, sh[7:0]};
            HALF:    res = {{16{sh[15]}}, sh[15:0]};
            WORD:    res = word;
            BYTE_U:  res = {24'd0, sh[7:0]};
            HALF_U:  res = {16'd0, sh[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane,
                                            input logic [2:0] f3);
        logic [3:0] be;
        case (f3)
            BYTE:    be = 4'b0001 << lane;
            HALF:    be = 4'b0011 << lane;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                               input logic [2:0]  f3);
        logic [31:0] d;
        case (f3)
            BYTE:    d = {4{wdata[7:0]}};
            HALF:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_bus_responder_dbus_ram.sv
// Backing store for the data bus responder.
//   clk   : clock
//   we    : write strobe, qualified per lane by be
//   be    : byte-lane enables
//   addr  : word index, shared by read and write
//   wdata : write data (lane-aligned)
//   rdata : registered read data, mem[addr] from the previous cycle
// Contents are never reset.
module dbus_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data bus responder: services level load/store requests from the control
// unit against a WORDS x 32 RAM with a fixed LATENCY of wait cycles.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   dbus_re   : level read request
//   dbus_we   : level write request
//   addr      : byte address
//   f3        : access width/sign (width_e)
//   wdata     : store data
//   rdata     : load result (0 after writes and faults)
//   stall     : holds the requester while an access is pending
//   fault     : access error, valid once stall drops
//   state_dbg : current FSM state
//
// Handshake: a request is a level on dbus_re/dbus_we. It is taken in IDLE,
// stall is high from the request cycle until the access completes, and the
// result holds in DONE until both request lines are seen low, so a held
// request is serviced exactly once.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbus_re,
    input  logic        dbus_we,
    input  logic [31:0] addr,
    input  logic [2:0]  f3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output resp_state_e state_dbg
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    resp_state_e state;
    logic [3:0]  cnt;
    logic [31:0] cap_addr;
    logic [2:0]  cap_f3;
    logic [31:0] cap_wdata;
    logic        cap_we;
    logic        cap_both;

    logic [1:0]    lane;
    logic          misalign;
    logic          out_of_range;
    logic          bad_f3;
    logic          acc_fault;
    logic          execute;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_q;

    assign lane         = cap_addr[1:0];
    assign out_of_range = cap_addr[31:2] >= 30'(WORDS);
    assign misalign     = (((cap_f3 == HALF) || (cap_f3 == HALF_U)) && cap_addr[0])
                        || ((cap_f3 == WORD) && (lane != 2'd0));
    // Stores only know signed-agnostic widths; loads reject the unused codes.
    assign bad_f3       = cap_we ? !((cap_f3 == BYTE) || (cap_f3 == HALF) || (cap_f3 == WORD))
                                 : ((cap_f3 == 3'd3) || (cap_f3 == 3'd6) || (cap_f3 == 3'd7));
    assign acc_fault    = cap_both || misalign || out_of_range || bad_f3;

    assign execute = (state == BUSY) && (cnt == 4'd0);
    assign ram_we  = execute && cap_we && !acc_fault;

    // In IDLE the RAM is pointed at the live address so the read word is
    // already registered by the first BUSY cycle, even with LATENCY=1.
    assign ram_addr = (state == IDLE) ? addr[AW+1:2] : cap_addr[AW+1:2];

    assign stall     = (state == BUSY) || ((state == IDLE) && (dbus_re || dbus_we));
    assign state_dbg = state;

    dbus_ram #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (store_be(lane, cap_f3)),
        .addr  (ram_addr),
        .wdata (store_data(cap_wdata, cap_f3)),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            fault     <= 1'b0;
            cap_addr  <= 32'd0;
            cap_f3    <= 3'd0;
            cap_wdata <= 32'd0;
            cap_we    <= 1'b0;
            cap_both  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbus_re || dbus_we) begin
                        cap_addr  <= addr;
                        cap_f3    <= f3;
                        cap_wdata <= wdata;
                        cap_we    <= dbus_we;
                        cap_both  <= dbus_re && dbus_we;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        fault <= acc_fault;
                        rdata <= (cap_we || acc_fault) ? 32'd0
                                                       : load_extend(ram_q, lane, cap_f3);
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!dbus_re && !dbus_we) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;
    import data_bus_responder_pkg::*;

    localparam int WORDS   = 1024;
    localparam int LATENCY = 2;
    localparam int EXP_STALL = LATENCY + 1;

    logic        clk;
    logic        rst;
    logic        dbus_re;
    logic        dbus_we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    resp_state_e state_dbg;

    int checks;
    int failures;

    data_bus_responder #(
        .WORDS   (WORDS),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dbus_re   (dbus_re),
        .dbus_we   (dbus_we),
        .addr      (addr),
        .f3        (f3),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One complete access: drive at a negedge, count stall-high cycles,
    // sample the result once stall drops, then release the request.
    task automatic do_access(input logic re, input logic we, input logic [31:0] a,
                             input logic [2:0] f, input logic [31:0] wd,
                             output int cyc, output logic [31:0] rd, output logic flt);
        @(negedge clk);
        dbus_re = re;
        dbus_we = we;
        addr    = a;
        f3      = f;
        wdata   = wd;
        #1;
        cyc = 0;
        while (stall && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        rd = rdata;
        flt = fault;
        dbus_re = 1'b0;
        dbus_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] exp_rd, input logic exp_flt);
        int cyc;
        logic [31:0] rd;
        logic flt;
        do_access(1'b1, 1'b0, a, f, 32'd0, cyc, rd, flt);
        check({tag, "_stall"}, 32'(cyc), 32'(EXP_STALL));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_flt});
    endtask

    task automatic wr_chk(input string tag, input logic re, input logic [31:0] a,
                          input logic [2:0] f, input logic [31:0] wd, input logic exp_flt);
        int cyc;
        logic [31:0] rd;
        logic flt;
        do_access(re, 1'b1, a, f, wd, cyc, rd, flt);
        check({tag, "_stall"}, 32'(cyc), 32'(EXP_STALL));
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_flt});
    endtask

    initial begin
        int highs;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        dbus_re  = 1'b0;
        dbus_we  = 1'b0;
        addr     = 32'd0;
        f3       = 3'd0;
        wdata    = 32'd0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;

        // word write/read and lane extraction
        wr_chk("wr_w10", 1'b0, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
        rd_chk("rd_w10", 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
        rd_chk("rd_b13", 32'h13, 3'd0, 32'hFFFFFFDE, 1'b0);
        rd_chk("rd_bu13", 32'h13, 3'd4, 32'h000000DE, 1'b0);
        rd_chk("rd_h10", 32'h10, 3'd1, 32'hFFFFBEEF, 1'b0);
        rd_chk("rd_hu12", 32'h12, 3'd5, 32'h0000DEAD, 1'b0);

        // byte store touches only its lane; rdata returns to 0 after a write
        wr_chk("wr_b11", 1'b0, 32'h11, 3'd0, 32'hAABBCC55, 1'b0);
        rd_chk("rd_w10b", 32'h10, 3'd2, 32'hDEAD55EF, 1'b0);
        rd_chk("rd_bu11", 32'h11, 3'd4, 32'h00000055, 1'b0);

        // faults
        rd_chk("rd_w12", 32'h12, 3'd2, 32'h0, 1'b1);
        rd_chk("rd_h11", 32'h11, 3'd1, 32'h0, 1'b1);
        rd_chk("rd_f3_3", 32'h10, 3'd3, 32'h0, 1'b1);
        wr_chk("wr_w0", 1'b0, 32'h0, 3'd2, 32'h01020304, 1'b0);
        wr_chk("wr_oob", 1'b0, 32'(WORDS * 4), 3'd2, 32'hCAFEBABE, 1'b1);
        rd_chk("rd_w0", 32'h0, 3'd2, 32'h01020304, 1'b0);
        wr_chk("wr_both", 1'b1, 32'h10, 3'd2, 32'h0BADF00D, 1'b1);
        wr_chk("wr_f3_4", 1'b0, 32'h10, 3'd4, 32'h0BADF00D, 1'b1);
        rd_chk("rd_w10c", 32'h10, 3'd2, 32'hDEAD55EF, 1'b0);

        // held write request: one access only, later data ignored
        @(negedge clk);
        dbus_we = 1'b1;
        addr    = 32'h40;
        f3      = 3'd2;
        wdata   = 32'h11111111;
        highs   = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (stall) highs++;
            if (i == 5) wdata = 32'h22222222;
            @(negedge clk);
        end
        check("hold_stall_cycles", 32'(highs), 32'(EXP_STALL));
        dbus_we = 1'b0;
        #1;
        check("hold_drop_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rd_chk("rd_w40", 32'h40, 3'd2, 32'h11111111, 1'b0);

        // reset in the middle of a write aborts it
        wr_chk("wr_w20", 1'b0, 32'h20, 3'd2, 32'hA5A5A5A5, 1'b0);
        rd_chk("rd_w20", 32'h20, 3'd2, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        dbus_we = 1'b1;
        addr    = 32'h20;
        f3      = 3'd2;
        wdata   = 32'h12345678;
        @(negedge clk);
        #1;
        check("pre_rst_state", 32'(state_dbg), 32'(BUSY));
        rst     = 1'b0;
        dbus_we = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_fault", {31'd0, fault}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_chk("rd_w20_after_rst", 32'h20, 3'd2, 32'hA5A5A5A5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameter WORDS, default 1024, depth of backing store in 32-bit words.
REQ-002 Parameter LATENCY, default 2, number of wait cycles per access; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 dbus_re  in  1  level read request from control unit.
REQ-006 dbus_we  in  1  level write request from control unit.
REQ-007 addr  in  32  byte address (ALU result).
REQ-008 f3  in  3  access width/sign: 0 byte, 1 half, 2 word, 4 byte-unsigned, 5 half-unsigned.
REQ-009 wdata  in  32  store data; low bytes used for byte/half stores.
REQ-010 rdata  out  32  load result, extended to 32 bits.
REQ-011 stall  out  1  holds the control unit while an access is pending.
REQ-012 fault  out  1  access error flag, valid alongside completion.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and DONE.
REQ-014 In IDLE, if dbus_re or dbus_we is sampled high at a posedge, the block SHALL capture addr, f3, wdata and the operation, load the wait counter with LATENCY-1, and enter BUSY.
REQ-015 stall SHALL be combinational: high in BUSY, and high in IDLE while dbus_re or dbus_we is high, so the requester stalls in the request cycle; stall SHALL be low otherwise.
REQ-016 In BUSY the counter SHALL decrement each cycle; at counter 0 the access SHALL execute and the state SHALL become DONE. Total stall-high cycles per access = LATENCY+1.
REQ-017 In DONE, rdata and fault SHALL hold their values; the block SHALL return to IDLE only after sampling dbus_re=0 and dbus_we=0, so a level request is serviced exactly once.
REQ-018 Reads SHALL select the byte or half lane from addr[1:0]: f3=0/1 sign-extend, f3=4/5 zero-extend, f3=2 full word.
REQ-019 Writes SHALL update only the addressed byte lanes; f3 values other than 0, 1 and 2 on a write are faults.
REQ-020 fault SHALL be set, with no memory write and rdata=0, on any of: dbus_re and dbus_we both high at capture; half access with addr[0]=1; word access with addr[1:0]!=0; addr[31:2] >= WORDS; read f3 in {3,6,7}.
REQ-021 rdata SHALL be 0 after a completed write.
REQ-022 Inputs changing while in BUSY or DONE SHALL be ignored; the captured values govern the access.

Reset
REQ-023 On rst low the block SHALL enter IDLE immediately, with rdata=0, fault=0 and the counter cleared; stall then follows REQ-015.
REQ-024 A reset during BUSY SHALL abort the access with no memory write; memory contents SHALL NOT be reset.

Structure
REQ-025 The width encoding enum (BYTE, HALF, WORD, BYTE_U, HALF_U) and the responder state enum SHALL live in the shared Types package.
REQ-026 The storage SHALL be a sub-module dbus_ram: WORDS x 32, 4-bit byte-enable write, synchronous read.

Verification
REQ-027 LATENCY=2, write word 0xDEADBEEF to 0x10, then read word 0x10 -> stall high 3 cycles each, rdata=0xDEADBEEF, fault=0.
REQ-028 After REQ-027: read byte (f3=0) at 0x13 -> 0xFFFFFFDE; byte-unsigned (f3=4) at 0x13 -> 0x000000DE; half (f3=1) at 0x10 -> 0xFFFFBEEF.
REQ-029 Store byte 0x55 to 0x11, then read word 0x10 -> 0xDEAD55EF.
REQ-030 Read word at 0x12 -> fault=1, rdata=0; write word at WORDS*4 -> fault=1 and memory unchanged.
REQ-031 Hold dbus_we high for 10 cycles -> exactly one write; no second stall until dbus_we drops for at least one cycle.
REQ-032 Assert rst mid-BUSY on a write of 0x12345678 to 0x20 -> immediate IDLE, stall=0, subsequent read of 0x20 returns the prior value.
